// File: rtl/router_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// router_fsm_ctrl
//
// Packet-routing controller for the 1xN router. Decodes the header address,
// latches the destination channel, and sequences header, payload and parity
// writes into that channel's FIFO. It also handles FIFO-full back-pressure and
// drops packets addressed to channels that do not exist. Per-channel status and
// soft-reset vectors are only observed for the latched channel.
//
// Optional feature: define ROUTER_WAIT_TIMEOUT_EN to bound the time spent in
// WAIT_TILL_EMPTY to WAIT_TIMEOUT cycles. On expiry the packet is dropped and
// wait_timeout pulses for one cycle. Without the macro, WAIT_TILL_EMPTY waits
// indefinitely and wait_timeout is tied low.
//
// Parameters:
//   NUM_CH        number of output channels (2..16)
//   ADDR_W        header address field width, taken from din[ADDR_W-1:0]
//   DATA_W        header/data bus width (>= ADDR_W)
//   WAIT_TIMEOUT  WAIT_TILL_EMPTY cycle limit (1..65535), timeout build only
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   pkt_valid       packet byte valid on din
//   din             header byte (address field) in DECODE_ADDRESS
//   fifo_full       per-channel FIFO full
//   fifo_empty      per-channel FIFO empty
//   soft_rst        per-channel soft reset from the FIFO read-timeout logic
//   parity_done     parity byte written
//   low_pkt_valid   pkt_valid fell during FIFO-full handling
//   detect_addr, lfd_state, ld_state, laf_state, full_state,
//   rst_int_req, drop_state   one-hot state flags
//   wr_en_req       FIFO write request
//   busy            router cannot accept a new byte
//   ch_sel          latched destination channel
//   wait_timeout    one-cycle pulse on WAIT_TILL_EMPTY timeout
// -----------------------------------------------------------------------------
module router_fsm_ctrl #(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned ADDR_W       = $clog2(NUM_CH),
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned WAIT_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] din,
   input  logic [NUM_CH-1:0] fifo_full,
   input  logic [NUM_CH-1:0] fifo_empty,
   input  logic [NUM_CH-1:0] soft_rst,
   input  logic              parity_done,
   input  logic              low_pkt_valid,
   output logic              detect_addr,
   output logic              lfd_state,
   output logic              ld_state,
   output logic              laf_state,
   output logic              full_state,
   output logic              rst_int_req,
   output logic              drop_state,
   output logic              wr_en_req,
   output logic              busy,
   output logic [ADDR_W-1:0] ch_sel,
   output logic              wait_timeout
);

   // Legacy-compatible state encodings; codes 9..15 are unused.
   localparam logic [3:0] DECODE_ADDRESS     = 4'd0;
   localparam logic [3:0] LOAD_FIRST_DATA    = 4'd1;
   localparam logic [3:0] LOAD_DATA          = 4'd2;
   localparam logic [3:0] LOAD_PARITY        = 4'd3;
   localparam logic [3:0] FIFO_FULL_STATE    = 4'd4;
   localparam logic [3:0] LOAD_AFTER_FULL    = 4'd5;
   localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd6;
   localparam logic [3:0] CHECK_PARITY_ERROR = 4'd7;
   localparam logic [3:0] DROP_PACKET        = 4'd8;

   // Elaboration-time parameter range checks.
   if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
      $error("router_fsm_ctrl: NUM_CH must be 2..16");
   end
   if (DATA_W < ADDR_W) begin : g_bad_data_w
      $error("router_fsm_ctrl: DATA_W must be >= ADDR_W");
   end
   if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 65535) begin : g_bad_timeout
      $error("router_fsm_ctrl: WAIT_TIMEOUT must be 1..65535");
   end

   logic [3:0]        state;
   logic [3:0]        next_state;
   logic [ADDR_W-1:0] hdr_addr;

   // Header decode and latched-channel status selection
   logic              hdr_valid;
   logic              hdr_empty;
   logic              sel_full;
   logic              sel_empty;
   logic              sel_soft_rst;
   logic              timeout_hit;

   assign hdr_addr = din[ADDR_W-1:0];

   if (DATA_W > ADDR_W) begin : g_din_hi
      // Bits above the address field carry no routing information.
      logic unused_din_hi;
      assign unused_din_hi = ^din[DATA_W-1:ADDR_W];
   end

   // Channel lookups are done by matching against every legal channel number,
   // so an out-of-range address (or latched ch_sel) simply selects nothing and
   // reads as "not valid / not full / not empty / no soft reset".
   always_comb begin
      hdr_valid    = 1'b0;
      hdr_empty    = 1'b0;
      sel_full     = 1'b0;
      sel_empty    = 1'b0;
      sel_soft_rst = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (hdr_addr == ADDR_W'(i)) begin
            hdr_valid = 1'b1;
            hdr_empty = fifo_empty[i];
         end
         if (ch_sel == ADDR_W'(i)) begin
            sel_full     = fifo_full[i];
            sel_empty    = fifo_empty[i];
            sel_soft_rst = soft_rst[i];
         end
      end
   end

`ifdef ROUTER_WAIT_TIMEOUT_EN
   // Cycles already spent in WAIT_TILL_EMPTY; the current cycle is the
   // (wait_cnt+1)-th, so the limit is hit when that reaches WAIT_TIMEOUT.
   logic [15:0] wait_cnt;
   logic        wait_timeout_q;

   assign timeout_hit = (state == WAIT_TILL_EMPTY) &&
                        ((wait_cnt + 16'd1) == 16'(WAIT_TIMEOUT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state != WAIT_TILL_EMPTY) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   // Registered so the pulse coincides with the first DROP_PACKET cycle; a
   // same-cycle empty or soft reset steers next_state away and suppresses it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_timeout_q <= 1'b0;
      end else begin
         wait_timeout_q <= (state == WAIT_TILL_EMPTY) &&
                           (next_state == DROP_PACKET);
      end
   end

   assign wait_timeout = wait_timeout_q;
`else
   assign timeout_hit  = 1'b0;
   assign wait_timeout = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         DECODE_ADDRESS: begin
            if (pkt_valid) begin
               if (!hdr_valid) begin
                  next_state = DROP_PACKET;
               end else if (hdr_empty) begin
                  next_state = LOAD_FIRST_DATA;
               end else begin
                  next_state = WAIT_TILL_EMPTY;
               end
            end
         end
         LOAD_FIRST_DATA: next_state = LOAD_DATA;
         LOAD_DATA: begin
            // Full takes precedence over end-of-packet.
            if (sel_full) begin
               next_state = FIFO_FULL_STATE;
            end else if (!pkt_valid) begin
               next_state = LOAD_PARITY;
            end
         end
         LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            next_state = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         FIFO_FULL_STATE: begin
            if (!sel_full) begin
               next_state = LOAD_AFTER_FULL;
            end
         end
         LOAD_AFTER_FULL: begin
            if (parity_done) begin
               next_state = DECODE_ADDRESS;
            end else if (low_pkt_valid) begin
               next_state = LOAD_PARITY;
            end else begin
               next_state = LOAD_DATA;
            end
         end
         WAIT_TILL_EMPTY: begin
            // Empty wins over a coincident timeout.
            if (sel_empty) begin
               next_state = LOAD_FIRST_DATA;
            end else if (timeout_hit) begin
               next_state = DROP_PACKET;
            end
         end
         DROP_PACKET: begin
            if (!pkt_valid) begin
               next_state = DECODE_ADDRESS;
            end
         end
         default: next_state = DECODE_ADDRESS;
      endcase

      // Soft reset of the latched channel overrides every transition.
      if ((state != DECODE_ADDRESS) && sel_soft_rst) begin
         next_state = DECODE_ADDRESS;
      end
   end

   // State and channel registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= DECODE_ADDRESS;
         ch_sel <= '0;
      end else begin
         state <= next_state;
         if ((state == DECODE_ADDRESS) && pkt_valid) begin
            ch_sel <= hdr_addr;
         end
      end
   end

   // Moore output decode
   assign detect_addr = (state == DECODE_ADDRESS);
   assign lfd_state   = (state == LOAD_FIRST_DATA);
   assign ld_state    = (state == LOAD_DATA);
   assign laf_state   = (state == LOAD_AFTER_FULL);
   assign full_state  = (state == FIFO_FULL_STATE);
   assign rst_int_req = (state == CHECK_PARITY_ERROR);
   assign drop_state  = (state == DROP_PACKET);
   assign wr_en_req   = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                        (state == LOAD_AFTER_FULL);
   assign busy        = (state != DECODE_ADDRESS) && (state != LOAD_DATA);

endmodule
